alu_issue_queue: RTL and testbench
==================================

# alu_issue_queue

Four-entry out-of-order reservation station that sits directly upstream of the ALU execute stage. It holds dispatched ALU micro-ops until both source operands are available. It captures operand values from the writeback broadcast, and issues at most one ready entry per cycle on registered EX_* outputs that drive the execute stage directly.

## Interface
- DEPTH, 4: entry count; fixed at 4 for this revision (index width 2).
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous clear on branch mispredict/exception; clears all entries and the issue register.
- D_valid  in  1  dispatch request this cycle.
- D_Operation  in  6  ALU opcode.
- D_imm  in  32  immediate.
- D_Src1, D_Src2  in  32 each  operand values, meaningful only when the matching ready bit is 1.
- D_Src1_Phy, D_Src2_Phy  in  6 each  physical source tags.
- D_Src1_rdy, D_Src2_rdy  in  1 each  operand already available at dispatch.
- D_Phydst  in  6  physical destination.
- D_Commit_Window  in  4  ROB slot id.
- WB_valid  in  1  writeback broadcast valid.
- WB_Phydst  in  6  broadcast tag.
- WB_Result  in  32  broadcast value.
- full  out  1  registered; 1 when all 4 entries are valid.
- count  out  3  registered occupancy, 0..4.
- EX_en  out  1  registered issue valid.
- EX_Operation  out  6  issued opcode.
- EX_imm, EX_Src1, EX_Src2  out  32 each  issued immediate and operands.
- EX_Phydst  out  6  issued destination.
- EX_Commit_Window  out  4  issued ROB slot.

## Operation
- Entry state: valid, op, imm, src1/src2 value, src1/src2 tag, src1/src2 rdy, Phydst, Commit_Window.
- Dispatch is accepted when D_valid=1 and full=0, using the registered full value of the current cycle. The entry is written into the lowest-index invalid entry. D_valid while full=1 is dropped silently; upstream must not assert it.
- Dispatch bypass: if WB_valid=1 and WB_Phydst equals a not-ready dispatched tag in the same cycle, that operand is written ready with WB_Result.
- Wakeup: each cycle, for every valid entry with srcN_rdy=0 and srcN tag == WB_Phydst while WB_valid=1, set srcN_rdy=1 and srcN value=WB_Result. Both operands may wake in the same cycle.
- Select: candidates are entries with valid=1, src1_rdy=1 and src2_rdy=1, evaluated on registered state. Wakeups from the current cycle are not visible to select until the next cycle. The lowest index wins.
- Issue: at the edge, EX_* are loaded from the winner, EX_en=1, and the winner's valid is cleared. With no winner, EX_en=0 and the EX_* data fields hold their previous values.
- Same cycle issue + dispatch: the freed entry is not reusable until the next cycle. The dispatch goes to a different free slot, or is blocked if full=1.
- count next = count + accepted_dispatch - issue; full = (count next == 4).
- flush: at the edge, all valid bits, EX_en, count and full go to 0. EX_* data fields go to 0. Dispatch and wakeup in the flush cycle are discarded.
- rst, asynchronous: all entries invalid; all outputs 0 (EX_en=0, EX_* fields 0, count=0, full=0). Reset asserted mid-operation kills in-flight entries immediately.

## Timing
- Minimum latency: an entry dispatched ready with both operands in cycle N is selected in cycle N+1 and appears with EX_en=1 after the N+1 edge, i.e. during cycle N+2.
- An entry woken by the broadcast in cycle W issues with EX_en=1 during cycle W+2 at the earliest.
- Throughput: 1 issue per cycle.
- There is no back-pressure from execute; the execute stage always accepts.

## Test plan
- Reset/idle: assert rst mid-run with 3 entries valid -> immediately count=0, full=0, EX_en=0, EX_* fields 0; no issue after release.
- Ready dispatch: D_valid with both rdy=1, Src1=0x5, Src2=0x7, Phydst=12, Commit_Window=3 in cycle 0 -> EX_en=1 in cycle 2 with the same fields; count back to 0.
- Wakeup/bypass:
  - Dispatch with Src1_Phy=9, rdy=0, then WB_valid, WB_Phydst=9, WB_Result=0xDEADBEEF in cycle 3 -> EX_Src1=0xDEADBEEF, EX_en=1 in cycle 5.
  - Repeat with the broadcast in the dispatch cycle -> issue 2 cycles after dispatch.
- Fill/full: 4 non-ready dispatches -> full=1, count=4; a 5th D_valid is dropped; waking one entry -> it issues and full drops.
- Priority: entries 0 and 2 become ready in the same cycle -> entry 0 issues first, entry 2 the next cycle.
- Flush: 3 valid entries, one selected this cycle, flush=1 -> next cycle EX_en=0, count=0, and no later issue of the flushed ops.

Source files
------------

// File: rtl/alu_issue_queue.sv
// Four-entry ALU reservation station: captures operands from the writeback broadcast and
// issues the lowest-index ready entry each cycle onto registered execute-stage outputs.
module alu_issue_queue #(
  parameter int unsigned Depth = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        flush_i,
  input  logic        d_valid_i,
  input  logic [5:0]  d_operation_i,
  input  logic [31:0] d_imm_i,
  input  logic [31:0] d_src1_i,
  input  logic [31:0] d_src2_i,
  input  logic [5:0]  d_src1_phy_i,
  input  logic [5:0]  d_src2_phy_i,
  input  logic        d_src1_rdy_i,
  input  logic        d_src2_rdy_i,
  input  logic [5:0]  d_phydst_i,
  input  logic [3:0]  d_commit_window_i,
  input  logic        wb_valid_i,
  input  logic [5:0]  wb_phydst_i,
  input  logic [31:0] wb_result_i,
  output logic        full_o,
  output logic [2:0]  count_o,
  output logic        ex_en_o,
  output logic [5:0]  ex_operation_o,
  output logic [31:0] ex_imm_o,
  output logic [31:0] ex_src1_o,
  output logic [31:0] ex_src2_o,
  output logic [5:0]  ex_phydst_o,
  output logic [3:0]  ex_commit_window_o
);

  localparam int unsigned IdxW = $clog2(Depth);

  logic [Depth-1:0] valid_q, valid_d, rdy1_q, rdy1_d, rdy2_q, rdy2_d;
  logic [5:0]       op_q   [Depth];
  logic [5:0]       op_d   [Depth];
  logic [31:0]      imm_q  [Depth];
  logic [31:0]      imm_d  [Depth];
  logic [31:0]      src1_q [Depth];
  logic [31:0]      src1_d [Depth];
  logic [31:0]      src2_q [Depth];
  logic [31:0]      src2_d [Depth];
  logic [5:0]       tag1_q [Depth];
  logic [5:0]       tag1_d [Depth];
  logic [5:0]       tag2_q [Depth];
  logic [5:0]       tag2_d [Depth];
  logic [5:0]       dst_q  [Depth];
  logic [5:0]       dst_d  [Depth];
  logic [3:0]       cw_q   [Depth];
  logic [3:0]       cw_d   [Depth];

  logic [2:0]  count_q, count_d;
  logic        full_q, full_d;
  logic        ex_en_q, ex_en_d;
  logic [5:0]  ex_op_q, ex_op_d;
  logic [31:0] ex_imm_q, ex_imm_d, ex_src1_q, ex_src1_d, ex_src2_q, ex_src2_d;
  logic [5:0]  ex_dst_q, ex_dst_d;
  logic [3:0]  ex_cw_q, ex_cw_d;

  logic            sel_found, free_found, accept;
  logic [IdxW-1:0] sel_idx, free_idx;

  // Select and free-slot search both look only at registered state, so an entry
  // issued this cycle is not reused until the next one.
  always_comb begin
    sel_found  = 1'b0;
    sel_idx    = '0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = 0; i < int'(Depth); i++) begin
      if (!sel_found && valid_q[i] && rdy1_q[i] && rdy2_q[i]) begin
        sel_found = 1'b1;
        sel_idx   = IdxW'(i);
      end
      if (!free_found && !valid_q[i]) begin
        free_found = 1'b1;
        free_idx   = IdxW'(i);
      end
    end
  end

  assign accept = d_valid_i && !full_q && free_found;

  always_comb begin
    valid_d   = valid_q;
    rdy1_d    = rdy1_q;
    rdy2_d    = rdy2_q;
    op_d      = op_q;
    imm_d     = imm_q;
    src1_d    = src1_q;
    src2_d    = src2_q;
    tag1_d    = tag1_q;
    tag2_d    = tag2_q;
    dst_d     = dst_q;
    cw_d      = cw_q;
    ex_en_d   = sel_found;
    ex_op_d   = ex_op_q;
    ex_imm_d  = ex_imm_q;
    ex_src1_d = ex_src1_q;
    ex_src2_d = ex_src2_q;
    ex_dst_d  = ex_dst_q;
    ex_cw_d   = ex_cw_q;

    for (int i = 0; i < int'(Depth); i++) begin
      if (valid_q[i] && wb_valid_i) begin
        if (!rdy1_q[i] && tag1_q[i] == wb_phydst_i) begin
          rdy1_d[i] = 1'b1;
          src1_d[i] = wb_result_i;
        end
        if (!rdy2_q[i] && tag2_q[i] == wb_phydst_i) begin
          rdy2_d[i] = 1'b1;
          src2_d[i] = wb_result_i;
        end
      end
    end

    if (sel_found) begin
      valid_d[sel_idx] = 1'b0;
      ex_op_d          = op_q[sel_idx];
      ex_imm_d         = imm_q[sel_idx];
      ex_src1_d        = src1_q[sel_idx];
      ex_src2_d        = src2_q[sel_idx];
      ex_dst_d         = dst_q[sel_idx];
      ex_cw_d          = cw_q[sel_idx];
    end

    if (accept) begin
      valid_d[free_idx] = 1'b1;
      op_d[free_idx]    = d_operation_i;
      imm_d[free_idx]   = d_imm_i;
      tag1_d[free_idx]  = d_src1_phy_i;
      tag2_d[free_idx]  = d_src2_phy_i;
      dst_d[free_idx]   = d_phydst_i;
      cw_d[free_idx]    = d_commit_window_i;
      rdy1_d[free_idx]  = d_src1_rdy_i;
      src1_d[free_idx]  = d_src1_i;
      rdy2_d[free_idx]  = d_src2_rdy_i;
      src2_d[free_idx]  = d_src2_i;
      if (!d_src1_rdy_i && wb_valid_i && d_src1_phy_i == wb_phydst_i) begin
        rdy1_d[free_idx] = 1'b1;
        src1_d[free_idx] = wb_result_i;
      end
      if (!d_src2_rdy_i && wb_valid_i && d_src2_phy_i == wb_phydst_i) begin
        rdy2_d[free_idx] = 1'b1;
        src2_d[free_idx] = wb_result_i;
      end
    end

    count_d = count_q + {2'b00, accept} - {2'b00, sel_found};
    full_d  = (count_d == 3'd4);

    if (flush_i) begin
      valid_d   = '0;
      count_d   = '0;
      full_d    = 1'b0;
      ex_en_d   = 1'b0;
      ex_op_d   = '0;
      ex_imm_d  = '0;
      ex_src1_d = '0;
      ex_src2_d = '0;
      ex_dst_d  = '0;
      ex_cw_d   = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q   <= '0;
      rdy1_q    <= '0;
      rdy2_q    <= '0;
      for (int i = 0; i < int'(Depth); i++) begin
        op_q[i]   <= '0;
        imm_q[i]  <= '0;
        src1_q[i] <= '0;
        src2_q[i] <= '0;
        tag1_q[i] <= '0;
        tag2_q[i] <= '0;
        dst_q[i]  <= '0;
        cw_q[i]   <= '0;
      end
      count_q   <= '0;
      full_q    <= 1'b0;
      ex_en_q   <= 1'b0;
      ex_op_q   <= '0;
      ex_imm_q  <= '0;
      ex_src1_q <= '0;
      ex_src2_q <= '0;
      ex_dst_q  <= '0;
      ex_cw_q   <= '0;
    end else begin
      valid_q   <= valid_d;
      rdy1_q    <= rdy1_d;
      rdy2_q    <= rdy2_d;
      op_q      <= op_d;
      imm_q     <= imm_d;
      src1_q    <= src1_d;
      src2_q    <= src2_d;
      tag1_q    <= tag1_d;
      tag2_q    <= tag2_d;
      dst_q     <= dst_d;
      cw_q      <= cw_d;
      count_q   <= count_d;
      full_q    <= full_d;
      ex_en_q   <= ex_en_d;
      ex_op_q   <= ex_op_d;
      ex_imm_q  <= ex_imm_d;
      ex_src1_q <= ex_src1_d;
      ex_src2_q <= ex_src2_d;
      ex_dst_q  <= ex_dst_d;
      ex_cw_q   <= ex_cw_d;
    end
  end

  assign full_o             = full_q;
  assign count_o            = count_q;
  assign ex_en_o            = ex_en_q;
  assign ex_operation_o     = ex_op_q;
  assign ex_imm_o           = ex_imm_q;
  assign ex_src1_o          = ex_src1_q;
  assign ex_src2_o          = ex_src2_q;
  assign ex_phydst_o        = ex_dst_q;
  assign ex_commit_window_o = ex_cw_q;

endmodule

// File: tb/tb_alu_issue_queue.sv
// Self-checking bench for alu_issue_queue: directed scenarios plus randomized traffic
// compared against an entry-list reference model.
module tb_alu_issue_queue;

  logic        clk = 1'b0;
  logic        rst, flush, d_valid;
  logic [5:0]  d_op, d_t1, d_t2, d_dst;
  logic [31:0] d_imm, d_s1, d_s2;
  logic        d_r1, d_r2;
  logic [3:0]  d_cw;
  logic        wb_valid;
  logic [5:0]  wb_tag;
  logic [31:0] wb_res;
  logic        full, ex_en;
  logic [2:0]  count;
  logic [5:0]  ex_op, ex_dst;
  logic [31:0] ex_imm, ex_s1, ex_s2;
  logic [3:0]  ex_cw;

  int checks = 0;
  int failures = 0;

  alu_issue_queue u_dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .flush_i           (flush),
    .d_valid_i         (d_valid),
    .d_operation_i     (d_op),
    .d_imm_i           (d_imm),
    .d_src1_i          (d_s1),
    .d_src2_i          (d_s2),
    .d_src1_phy_i      (d_t1),
    .d_src2_phy_i      (d_t2),
    .d_src1_rdy_i      (d_r1),
    .d_src2_rdy_i      (d_r2),
    .d_phydst_i        (d_dst),
    .d_commit_window_i (d_cw),
    .wb_valid_i        (wb_valid),
    .wb_phydst_i       (wb_tag),
    .wb_result_i       (wb_res),
    .full_o            (full),
    .count_o           (count),
    .ex_en_o           (ex_en),
    .ex_operation_o    (ex_op),
    .ex_imm_o          (ex_imm),
    .ex_src1_o         (ex_s1),
    .ex_src2_o         (ex_s2),
    .ex_phydst_o       (ex_dst),
    .ex_commit_window_o(ex_cw)
  );

  always #5 clk = ~clk;

  // Reference model: a list of waiting micro-ops plus the last issued one.
  typedef struct {
    bit          v;
    logic [5:0]  op;
    logic [31:0] imm, a, b;
    logic [5:0]  ta, tb;
    bit          ra, rb;
    logic [5:0]  dst;
    logic [3:0]  cw;
  } ent_t;

  ent_t        m[4];
  int          m_count;
  bit          m_en;
  logic [5:0]  m_op, m_dst;
  logic [31:0] m_imm, m_a, m_b;
  logic [3:0]  m_cw;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m[i].v = 0;
    m_count = 0; m_en = 0; m_op = 0; m_dst = 0; m_imm = 0; m_a = 0; m_b = 0; m_cw = 0;
  endtask

  task automatic model_step();
    ent_t nx[4];
    int   win = -1;
    int   fr = -1;
    if (flush) begin
      model_reset();
      return;
    end
    nx = m;
    for (int i = 3; i >= 0; i--) begin
      if (m[i].v && m[i].ra && m[i].rb) win = i;
      if (!m[i].v) fr = i;
    end
    for (int i = 0; i < 4; i++) begin
      if (nx[i].v && wb_valid) begin
        if (!nx[i].ra && nx[i].ta == wb_tag) begin nx[i].ra = 1; nx[i].a = wb_res; end
        if (!nx[i].rb && nx[i].tb == wb_tag) begin nx[i].rb = 1; nx[i].b = wb_res; end
      end
    end
    m_en = (win >= 0);
    if (win >= 0) begin
      m_op = m[win].op; m_imm = m[win].imm; m_a = m[win].a; m_b = m[win].b;
      m_dst = m[win].dst; m_cw = m[win].cw;
      nx[win].v = 0;
    end
    if (d_valid && m_count < 4) begin
      nx[fr].v = 1; nx[fr].op = d_op; nx[fr].imm = d_imm; nx[fr].ta = d_t1; nx[fr].tb = d_t2;
      nx[fr].dst = d_dst; nx[fr].cw = d_cw;
      nx[fr].ra = d_r1 || (wb_valid && wb_tag == d_t1);
      nx[fr].a  = d_r1 ? d_s1 : wb_res;
      nx[fr].rb = d_r2 || (wb_valid && wb_tag == d_t2);
      nx[fr].b  = d_r2 ? d_s2 : wb_res;
      m_count++;
    end
    if (win >= 0) m_count--;
    m = nx;
  endtask

  task automatic idle();
    d_valid = 0; wb_valid = 0; flush = 0;
  endtask

  task automatic disp(input logic [5:0] op, input logic [31:0] imm, input logic [31:0] a,
                      input logic [31:0] b, input logic [5:0] ta, input logic [5:0] tb,
                      input logic ra, input logic rb, input logic [5:0] dst,
                      input logic [3:0] cw);
    d_valid = 1; d_op = op; d_imm = imm; d_s1 = a; d_s2 = b; d_t1 = ta; d_t2 = tb;
    d_r1 = ra; d_r2 = rb; d_dst = dst; d_cw = cw;
  endtask

  task automatic wb(input logic [5:0] t, input logic [31:0] r);
    wb_valid = 1; wb_tag = t; wb_res = r;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else model_step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1; idle();
    disp(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); d_valid = 0;
    wb_tag = 0; wb_res = 0;
    tick(); tick();
    checks++;
    if ({full, count, ex_en, ex_op, ex_imm, ex_s1, ex_s2, ex_dst, ex_cw} !== '0) begin
      failures++;
      $display("FAIL reset_state: got full=%b count=%0d ex_en=%b cw=%h, want all zero",
               full, count, ex_en, ex_cw);
    end
    rst = 0;
    tick();
  endtask

  task automatic test_ready_dispatch();
    disp(6'h11, 32'h100, 32'h5, 32'h7, 0, 0, 1, 1, 6'd12, 4'd3);
    tick(); idle();
    checks++;
    if (ex_en !== 1'b0 || count !== 3'd1) begin
      failures++;
      $display("FAIL ready_latency1: got ex_en=%b count=%0d, want ex_en=0 count=1", ex_en, count);
    end
    tick();
    checks++;
    if ({ex_en, ex_op, ex_imm, ex_s1, ex_s2, ex_dst, ex_cw} !==
        {1'b1, 6'h11, 32'h100, 32'h5, 32'h7, 6'd12, 4'd3} || count !== 3'd0) begin
      failures++;
      $display("FAIL ready_issue: got en=%b op=%h s1=%h s2=%h dst=%0d cw=%0d count=%0d, want 1 11 5 7 12 3 0",
               ex_en, ex_op, ex_s1, ex_s2, ex_dst, ex_cw, count);
    end
    tick();
  endtask

  task automatic test_wakeup();
    disp(6'h2, 32'h0, 32'h0, 32'h33, 6'd9, 6'd0, 0, 1, 6'd13, 4'd4);
    tick(); idle();
    tick(); tick();
    wb(6'd9, 32'hDEADBEEF);
    tick(); idle();
    checks++;
    if (ex_en !== 1'b0) begin
      failures++;
      $display("FAIL wakeup_early: got ex_en=%b, want 0", ex_en);
    end
    tick();
    checks++;
    if (ex_en !== 1'b1 || ex_s1 !== 32'hDEADBEEF || ex_s2 !== 32'h33 || ex_cw !== 4'd4) begin
      failures++;
      $display("FAIL wakeup_issue: got en=%b s1=%h s2=%h cw=%0d, want 1 deadbeef 33 4",
               ex_en, ex_s1, ex_s2, ex_cw);
    end
    disp(6'h3, 32'h1, 32'h0, 32'h0, 6'd10, 6'd10, 0, 0, 6'd14, 4'd5);
    wb(6'd10, 32'hCAFEF00D);
    tick(); idle();
    tick();
    checks++;
    if (ex_en !== 1'b1 || ex_s1 !== 32'hCAFEF00D || ex_s2 !== 32'hCAFEF00D || ex_cw !== 4'd5) begin
      failures++;
      $display("FAIL bypass_issue: got en=%b s1=%h s2=%h cw=%0d, want 1 cafef00d cafef00d 5",
               ex_en, ex_s1, ex_s2, ex_cw);
    end
    tick();
  endtask

  task automatic test_fill();
    for (int i = 0; i < 4; i++) begin
      disp(6'(i), 32'(i), 32'h0, 32'h9, 6'(20 + i), 6'd0, 0, 1, 6'(40 + i), 4'(8 + i));
      tick();
    end
    idle();
    checks++;
    if (full !== 1'b1 || count !== 3'd4) begin
      failures++;
      $display("FAIL fill_full: got full=%b count=%0d, want 1 4", full, count);
    end
    disp(6'h3f, 32'h0, 32'h1, 32'h1, 0, 0, 1, 1, 6'd63, 4'd15);
    tick(); idle(); tick();
    checks++;
    if (full !== 1'b1 || count !== 3'd4 || ex_en !== 1'b0) begin
      failures++;
      $display("FAIL fill_drop: got full=%b count=%0d ex_en=%b, want 1 4 0", full, count, ex_en);
    end
    wb(6'd22, 32'h1234);
    tick(); idle(); tick();
    checks++;
    if (ex_en !== 1'b1 || ex_cw !== 4'd10 || ex_s1 !== 32'h1234 || count !== 3'd3 ||
        full !== 1'b0) begin
      failures++;
      $display("FAIL fill_drain: got en=%b cw=%0d s1=%h count=%0d full=%b, want 1 10 1234 3 0",
               ex_en, ex_cw, ex_s1, count, full);
    end
    flush = 1; tick(); idle();
  endtask

  task automatic test_priority();
    disp(6'h1, 0, 0, 1, 6'd30, 0, 0, 1, 6'd1, 4'd1); tick();
    disp(6'h2, 0, 0, 1, 6'd31, 0, 0, 1, 6'd2, 4'd2); tick();
    disp(6'h3, 0, 0, 1, 6'd30, 0, 0, 1, 6'd3, 4'd3); tick();
    idle(); wb(6'd30, 32'h77);
    tick(); idle(); tick();
    checks++;
    if (ex_en !== 1'b1 || ex_cw !== 4'd1) begin
      failures++;
      $display("FAIL priority_first: got en=%b cw=%0d, want 1 1", ex_en, ex_cw);
    end
    tick();
    checks++;
    if (ex_en !== 1'b1 || ex_cw !== 4'd3 || ex_s1 !== 32'h77) begin
      failures++;
      $display("FAIL priority_second: got en=%b cw=%0d s1=%h, want 1 3 77", ex_en, ex_cw, ex_s1);
    end
    tick();
    checks++;
    if (ex_en !== 1'b0 || count !== 3'd1) begin
      failures++;
      $display("FAIL priority_idle: got en=%b count=%0d, want 0 1", ex_en, count);
    end
    flush = 1; tick(); idle();
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin
      disp(6'h5, 0, 0, 2, 6'd35, 0, 0, 1, 6'd7, 4'(i + 1));
      tick();
    end
    idle(); wb(6'd35, 32'h55);
    tick(); idle();
    flush = 1;
    tick(); idle();
    checks++;
    if (ex_en !== 1'b0 || count !== 3'd0 || full !== 1'b0 || ex_cw !== 4'd0 || ex_s1 !== '0) begin
      failures++;
      $display("FAIL flush_clear: got en=%b count=%0d full=%b cw=%0d s1=%h, want all zero",
               ex_en, count, full, ex_cw, ex_s1);
    end
    for (int i = 0; i < 3; i++) begin
      wb(6'd35, 32'h66);
      tick(); idle();
      checks++;
      if (ex_en !== 1'b0 || count !== 3'd0) begin
        failures++;
        $display("FAIL flush_no_issue: got en=%b count=%0d, want 0 0", ex_en, count);
      end
    end
  endtask

  task automatic test_reset_midrun();
    for (int i = 0; i < 3; i++) begin
      disp(6'h9, 32'h9, 0, 0, 6'(50 + i), 6'(50 + i), 0, 0, 6'd8, 4'(i + 6));
      tick();
    end
    idle();
    wb(6'd50, 32'hAA);
    #2 rst = 1;
    #1;
    model_reset();
    checks++;
    if ({full, count, ex_en, ex_op, ex_imm, ex_s1, ex_s2, ex_dst, ex_cw} !== '0) begin
      failures++;
      $display("FAIL reset_async: got full=%b count=%0d ex_en=%b cw=%h, want all zero",
               full, count, ex_en, ex_cw);
    end
    tick(); idle();
    rst = 0;
    for (int i = 0; i < 4; i++) begin
      wb(6'(50 + (i % 3)), 32'hBB);
      tick(); idle();
      checks++;
      if (ex_en !== 1'b0 || count !== 3'd0) begin
        failures++;
        $display("FAIL reset_no_issue: got en=%b count=%0d, want 0 0", ex_en, count);
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      d_valid  = ($urandom_range(0, 2) != 0);
      d_op     = 6'($urandom);
      d_imm    = $urandom;
      d_s1     = $urandom;
      d_s2     = $urandom;
      d_t1     = 6'($urandom_range(0, 7));
      d_t2     = 6'($urandom_range(0, 7));
      d_r1     = ($urandom_range(0, 2) == 0);
      d_r2     = ($urandom_range(0, 2) == 0);
      d_dst    = 6'($urandom);
      d_cw     = 4'($urandom);
      wb_valid = ($urandom_range(0, 1) == 1);
      wb_tag   = 6'($urandom_range(0, 7));
      wb_res   = $urandom;
      flush    = ($urandom_range(0, 39) == 0);
      tick();
      checks++;
      if ({full, count, ex_en, ex_op, ex_imm, ex_s1, ex_s2, ex_dst, ex_cw} !==
          {(m_count == 4), 3'(m_count), m_en, m_op, m_imm, m_a, m_b, m_dst, m_cw}) begin
        failures++;
        $display("FAIL random[%0d]: got full=%b cnt=%0d en=%b op=%h s1=%h s2=%h cw=%h, want %b %0d %b %h %h %h %h",
                 n, full, count, ex_en, ex_op, ex_s1, ex_s2, ex_cw,
                 (m_count == 4), m_count, m_en, m_op, m_a, m_b, m_cw);
      end
    end
    idle();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_ready_dispatch();
    test_wakeup();
    test_fill();
    test_priority();
    test_flush();
    test_reset_midrun();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
